// File: rtl/shift_cmd_queue.sv
// Command queue and result register around a combinational barrel rotator.
// Latency: minimum 2 edges from command acceptance to out_valid; 1 result/cycle sustained.
// Backpressure: in_ready drops at DEPTH queued; the held result stalls while out_ready=0.
module shift_cmd_queue #(
   parameter int WIDTH       = 8,
   parameter int SHIFT_WIDTH = 3,
   parameter int DEPTH       = 4,
   parameter int PTR_W       = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SHIFT_WIDTH-1:0] in_amount,
   input  logic                   in_dir,
   output logic [WIDTH-1:0]       sh_data_in,
   output logic [SHIFT_WIDTH-1:0] sh_shift_amount,
   output logic                   sh_direction,
   input  logic [WIDTH-1:0]       sh_data_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [PTR_W:0]         count
);

   // Entry layout: {data, amount, dir}
   localparam int ENTRY_W = WIDTH + SHIFT_WIDTH + 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [ENTRY_W-1:0] head;
   logic               push;
   logic               issue;
   logic               not_empty;

   assign not_empty = (count != '0);
   assign in_ready  = (count != FULL_CNT);
   assign push      = in_valid && in_ready;
   // The output slot is free when empty or being handed off this cycle.
   assign issue     = not_empty && (!out_valid || out_ready);
   assign head      = mem[rd_ptr];

   // Present the head entry to the rotator; quiet zeros when nothing is queued.
   always_comb begin
      sh_data_in      = '0;
      sh_shift_amount = '0;
      sh_direction    = 1'b0;
      if (not_empty) begin
         sh_data_in      = head[ENTRY_W-1 -: WIDTH];
         sh_shift_amount = head[SHIFT_WIDTH:1];
         sh_direction    = head[0];
      end
   end

   // Queue storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_data, in_amount, in_dir};
      end
   end

   // Pointers and occupancy; reset wins over any push/issue on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, issue})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Result holding register: capture on issue, clear valid on a bare handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_data  <= sh_data_out;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed bench for shift_cmd_queue with a behavioural rotator on the sh_* loop.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Expected values are hand-computed constants.
module tb_shift_cmd_queue;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_amount;
   logic       in_dir;
   logic [7:0] sh_data_in;
   logic [2:0] sh_shift_amount;
   logic       sh_direction;
   logic [7:0] sh_data_out;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] count;

   int checks;
   int failures;

   shift_cmd_queue #(
      .WIDTH(8), .SHIFT_WIDTH(3), .DEPTH(4), .PTR_W(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_amount(in_amount),
      .in_dir(in_dir),
      .sh_data_in(sh_data_in),
      .sh_shift_amount(sh_shift_amount),
      .sh_direction(sh_direction),
      .sh_data_out(sh_data_out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural rotator: dir 1 = left, 0 = right.
   always_comb begin
      logic [15:0] dbl;
      dbl = {sh_data_in, sh_data_in};
      if (sh_direction)
         sh_data_out = 8'((dbl << sh_shift_amount) >> 8);
      else
         sh_data_out = 8'(dbl >> sh_shift_amount);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic v, input logic [7:0] d, input logic [2:0] a, input logic dr);
      in_valid  = v;
      in_data   = d;
      in_amount = a;
      in_dir    = dr;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      set_cmd(1'b1, 8'hFF, 3'd1, 1'b1);
      tick();
      tick();
      checks += 4;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      rst = 1'b0;
      set_cmd(1'b0, 8'h00, 3'd0, 1'b0);
      tick();
      checks += 2;
      if (count !== 3'd0) begin failures++; $display("FAIL reset_no_capture_count got=%0d exp=0", count); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_no_capture_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_single_left();
      out_ready = 1'b1;
      set_cmd(1'b1, 8'hB4, 3'd3, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
      tick();
      set_cmd(1'b0, 8'h00, 3'd0, 1'b0);
      checks += 3;
      if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
      if (sh_data_in !== 8'hB4) begin failures++; $display("FAIL single_sh_data_in got=%h exp=b4", sh_data_in); end
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      if (out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", out_data); end
      if (count !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count); end
      tick();
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", out_valid); end
      if (sh_data_in !== 8'h00) begin failures++; $display("FAIL single_sh_idle got=%h exp=00", sh_data_in); end
   endtask

   task automatic test_right_zero();
      out_ready = 1'b1;
      set_cmd(1'b1, 8'h01, 3'd1, 1'b0);
      tick();
      set_cmd(1'b1, 8'h5A, 3'd0, 1'b1);
      tick();
      set_cmd(1'b0, 8'h00, 3'd0, 1'b0);
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL rz_first_valid got=%b exp=1", out_valid); end
      if (out_data !== 8'h80) begin failures++; $display("FAIL rz_first_data got=%h exp=80", out_data); end
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL rz_second_valid got=%b exp=1", out_valid); end
      if (out_data !== 8'h5A) begin failures++; $display("FAIL rz_second_data got=%h exp=5a", out_data); end
      if (count !== 3'd0) begin failures++; $display("FAIL rz_count got=%0d exp=0", count); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rz_drop got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [7:0] din [6];
      logic [7:0] exp [5];
      int accepted;
      din = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      exp = '{8'h22, 8'h44, 8'h66, 8'h88, 8'hAA};
      accepted = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_cmd(1'b1, din[i], 3'd1, 1'b1);
         if (in_ready === 1'b1) accepted++;
         tick();
      end
      set_cmd(1'b0, 8'h00, 3'd0, 1'b0);
      checks += 5;
      if (accepted != 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", accepted); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      if (count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", count); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
      if (out_data !== exp[0]) begin failures++; $display("FAIL bp_held got=%h exp=%h", out_data, exp[0]); end
      tick();
      checks++;
      if (out_data !== exp[0]) begin failures++; $display("FAIL bp_stable got=%h exp=%h", out_data, exp[0]); end
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         checks += 2;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid[%0d] got=%b exp=1", i, out_valid); end
         if (out_data !== exp[i]) begin failures++; $display("FAIL bp_drain_data[%0d] got=%h exp=%h", i, out_data, exp[i]); end
      end
      tick();
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
      if (count !== 3'd0) begin failures++; $display("FAIL bp_end_count got=%0d exp=0", count); end
   endtask

   task automatic test_full_simul();
      logic [7:0] exp [4];
      exp = '{8'h03, 8'h04, 8'h05, 8'h06};
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         set_cmd(1'b1, 8'(i), 3'd0, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      set_cmd(1'b1, 8'h06, 3'd0, 1'b0);
      checks += 3;
      if (count !== 3'd4) begin failures++; $display("FAIL full_count4 got=%0d exp=4", count); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      if (out_data !== 8'h01) begin failures++; $display("FAIL full_head got=%h exp=01", out_data); end
      tick();
      checks += 3;
      if (count !== 3'd3) begin failures++; $display("FAIL full_count3 got=%0d exp=3", count); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_again got=%b exp=1", in_ready); end
      if (out_data !== 8'h02) begin failures++; $display("FAIL full_second got=%h exp=02", out_data); end
      tick();
      set_cmd(1'b0, 8'h00, 3'd0, 1'b0);
      checks++;
      if (count !== 3'd3) begin failures++; $display("FAIL full_push_issue_count got=%0d exp=3", count); end
      for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL full_drain_valid[%0d] got=%b exp=1", i, out_valid); end
         if (out_data !== exp[i]) begin failures++; $display("FAIL full_drain_data[%0d] got=%h exp=%h", i, out_data, exp[i]); end
         tick();
      end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL full_end_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_cmd(1'b1, 8'(8'h07 + i), 3'd2, 1'b1);
         tick();
      end
      checks += 2;
      if (count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
      rst = 1'b1;
      out_ready = 1'b1;
      set_cmd(1'b1, 8'h77, 3'd1, 1'b0);
      tick();
      rst = 1'b0;
      set_cmd(1'b0, 8'h00, 3'd0, 1'b0);
      checks += 3;
      if (count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
      if (out_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", out_data); end
      tick();
      checks += 2;
      if (count !== 3'd0) begin failures++; $display("FAIL mid_after_count got=%0d exp=0", count); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_after_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d   [10];
      logic [2:0] a   [10];
      logic       dr  [10];
      logic [7:0] exp [10];
      d   = '{8'h01, 8'h80, 8'h0F, 8'h12, 8'hC3, 8'h81, 8'h55, 8'hAA, 8'h3C, 8'hF1};
      a   = '{3'd1,  3'd1,  3'd4,  3'd4,  3'd2,  3'd7,  3'd1,  3'd0,  3'd3,  3'd5};
      dr  = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
      exp = '{8'h02, 8'h01, 8'hF0, 8'h21, 8'hF0, 8'hC0, 8'hAA, 8'hAA, 8'hE1, 8'h8F};
      out_ready = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         if (k < 10) begin
            set_cmd(1'b1, d[k], a[k], dr[k]);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", k, in_ready); end
         end else begin
            set_cmd(1'b0, 8'h00, 3'd0, 1'b0);
         end
         tick();
         if (k >= 1) begin
            checks += 2;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k-1, out_valid); end
            if (out_data !== exp[k-1]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k-1, out_data, exp[k-1]); end
         end
      end
      tick();
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", out_valid); end
      if (count !== 3'd0) begin failures++; $display("FAIL b2b_end_count got=%0d exp=0", count); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      out_ready = 1'b0;
      set_cmd(1'b0, 8'h00, 3'd0, 1'b0);
      test_reset();
      test_single_left();
      test_right_zero();
      test_backpressure();
      test_full_simul();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
